// File: rtl/obi_mem_responder_if.sv
// OBI data-port bundle between the vector LSU (master) and a memory responder (slave).
// Signal names keep the responder-side _i/_o suffixes so both ends read the same.
interface obi_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/obi_mem_responder.sv
// OBI word memory responder: byte-enabled writes, fixed-latency in-order responses,
// bounded outstanding transactions and an injectable grant stall.
module obi_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned RSP_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              gnt_stall_i,
  obi_mem_responder_if.slave bus
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [RSP_LATENCY-1:0]        vld_q, vld_d;
  logic [RSP_LATENCY-1:0][31:0]  rdata_q, rdata_d;
  logic [RSP_LATENCY-1:0]        err_q, err_d;
  logic [CW-1:0]                 cnt_q, cnt_d;

  logic        gnt;
  logic        accept;
  logic        rvalid;
  logic        in_range;
  logic        mem_we;
  logic [29:0] word_off;
  logic [32:0] addr_ext;
  logic [IW-1:0] idx;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  // Address decode; bits [1:0] never select anything.
  always_comb begin
    addr_ext = {1'b0, bus.data_addr_i[31:2], 2'b00};
    word_off = bus.data_addr_i[31:2] - BASE_ADDR[31:2];
    idx      = word_off[IW-1:0];
    in_range = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < END_ADDR);
    rd_word  = in_range ? mem_q[idx] : 32'h0;
  end

  assign unused_addr_bits = ^{word_off, bus.data_addr_i[1:0]};

  // A response leaving the pipe this cycle frees its slot for a new accept.
  always_comb begin
    rvalid = vld_q[RSP_LATENCY-1];
    gnt    = n_reset & bus.data_req_i & ~gnt_stall_i &
             ((cnt_q < CW'(MAX_OUTSTANDING)) | rvalid);
    accept = gnt;
    mem_we = accept & bus.data_we_i & in_range;
    cnt_d  = cnt_q + CW'(accept) - CW'(rvalid);
  end

  always_comb begin
    vld_d      = '0;
    rdata_d    = '0;
    err_d      = '0;
    vld_d[0]   = accept;
    rdata_d[0] = (accept & in_range & ~bus.data_we_i) ? rd_word : 32'h0;
    err_d[0]   = accept & ~in_range;
    for (int i = 1; i < int'(RSP_LATENCY); i++) begin
      vld_d[i]   = vld_q[i-1];
      rdata_d[i] = rdata_q[i-1];
      err_d[i]   = err_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage deliberately has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.data_be_i[n]) mem_q[idx][8*n +: 8] <= bus.data_wdata_i[8*n +: 8];
      end
    end
  end

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = rvalid;
  assign bus.data_rdata_o  = rdata_q[RSP_LATENCY-1];
  assign bus.data_err_o    = err_q[RSP_LATENCY-1];

endmodule
